step_sequencer: RTL and testbench

Parametrised N-channel step/direction pulse generator: the successor to the single-axis, fixed-speed stepping in the current top level. It accepts move commands (channel, direction, step count, step period) over a valid/ready handshake. It drives a STEP/DIR pair per axis with a guaranteed direction-setup time, pulse width and exact step count, and reports busy/done per channel. It sits between the top-level control logic and the driver chips' STEP/DIR pins, alongside the existing SPI configuration path.

---
 rtl/stepper_pkg.sv | 23 ++
 rtl/step_channel.sv | 158 +++++++++++++++
 rtl/step_sequencer.sv | 74 +++++++
 tb/tb_step_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and default sizing for the STEP/DIR sequencer.
package stepper_pkg;

    // Per-axis phase of a move.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_t;

    localparam int DEF_CHANNELS  = 2;
    localparam int DEF_COUNT_W   = 24;
    localparam int DEF_PERIOD_W  = 16;
    localparam int DEF_PULSE_W   = 8;
    localparam int DEF_DIR_SETUP = 8;

    // Width of a channel index; a single axis still gets a 1-bit field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_channel.sv
// One STEP/DIR axis: setup delay, pulse/gap timing, step counting,
// pause and abort handling. All pin-facing outputs are registered.
module step_channel
    import stepper_pkg::*;
#(
    parameter int COUNT_W   = DEF_COUNT_W,
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_count,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    input  logic                enable,
    output logic                idle,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done
);

    // Phase timer must hold the period as well as the setup and pulse lengths.
    localparam int TMR_A = ($clog2(PULSE_W + 2) > $clog2(DIR_SETUP + 1)) ?
                           $clog2(PULSE_W + 2) : $clog2(DIR_SETUP + 1);
    localparam int TMR_W = (PERIOD_W > TMR_A) ? PERIOD_W : TMR_A;

    step_state_t        state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [TMR_W-1:0]   low_rld, low_rld_nxt;
    logic [COUNT_W-1:0] rem, rem_nxt;
    logic               step_nxt, dir_nxt, busy_nxt, done_nxt;
    logic               zero_pend, zero_pend_nxt;

    // LOW-phase reload value (length - 1) after clamping the period so
    // that at least one LOW cycle always follows the pulse.
    function automatic logic [TMR_W-1:0] low_reload(input logic [PERIOD_W-1:0] period);
        logic [TMR_W-1:0] p;
        p = TMR_W'(period);
        if (p < TMR_W'(PULSE_W + 1)) begin
            p = TMR_W'(PULSE_W + 1);
        end
        return p - TMR_W'(PULSE_W) - TMR_W'(1);
    endfunction

    assign idle = (state == IDLE);

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            low_rld   <= '0;
            rem       <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            low_rld   <= low_rld_nxt;
            rem       <= rem_nxt;
            step      <= step_nxt;
            dir       <= dir_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            zero_pend <= zero_pend_nxt;
        end
    end

    // Next-state logic: abort wins, a paused channel holds everything.
    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        low_rld_nxt   = low_rld;
        rem_nxt       = rem;
        step_nxt      = step;
        dir_nxt       = dir;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        zero_pend_nxt = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
            rem_nxt   = '0;
            step_nxt  = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A zero-length move completes one cycle after accept.
                    done_nxt = zero_pend;
                    if (start) begin
                        if (cmd_count == '0) begin
                            zero_pend_nxt = 1'b1;
                        end else begin
                            state_nxt   = SETUP;
                            dir_nxt     = cmd_dir;
                            busy_nxt    = 1'b1;
                            rem_nxt     = cmd_count;
                            tmr_nxt     = TMR_W'(DIR_SETUP - 1);
                            low_rld_nxt = low_reload(cmd_period);
                        end
                    end
                end
                SETUP: begin
                    if (enable) begin
                        if (tmr == '0) begin
                            state_nxt = HIGH;
                            step_nxt  = 1'b1;
                            tmr_nxt   = TMR_W'(PULSE_W - 1);
                        end else begin
                            tmr_nxt = tmr - TMR_W'(1);
                        end
                    end
                end
                HIGH: begin
                    if (enable) begin
                        if (tmr == '0) begin
                            state_nxt = LOW;
                            step_nxt  = 1'b0;
                            tmr_nxt   = low_rld;
                        end else begin
                            tmr_nxt = tmr - TMR_W'(1);
                        end
                    end
                end
                LOW: begin
                    if (enable) begin
                        if (tmr != '0) begin
                            tmr_nxt = tmr - TMR_W'(1);
                        end else if (rem == COUNT_W'(1)) begin
                            state_nxt = IDLE;
                            rem_nxt   = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            rem_nxt   = rem - COUNT_W'(1);
                            state_nxt = HIGH;
                            step_nxt  = 1'b1;
                            tmr_nxt   = TMR_W'(PULSE_W - 1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// N-axis STEP/DIR generator: command decode, ready muxing and fan-out
// to one step_channel per axis.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int PULSE_W     = DEF_PULSE_W,
    parameter int DIR_SETUP   = DEF_DIR_SETUP,
    localparam int CH_W       = ch_width(CHANNELS)
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic                cmd_valid_in,
    output logic                cmd_ready_out,
    input  logic [CH_W-1:0]     cmd_channel_in,
    input  logic                cmd_dir_in,
    input  logic [COUNT_W-1:0]  cmd_count_in,
    input  logic [PERIOD_W-1:0] cmd_period_in,
    input  logic [CHANNELS-1:0] abort_in,
    input  logic [CHANNELS-1:0] step_enable_in,
    output logic [CHANNELS-1:0] step_out,
    output logic [CHANNELS-1:0] dir_out,
    output logic [CHANNELS-1:0] busy_out,
    output logic [CHANNELS-1:0] done_out
);

    localparam int CH_SPAN = 1 << CH_W;
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0] ch_idle;
    logic [CHANNELS-1:0] ch_start;
    logic [CH_SPAN-1:0]  free_pad;
    logic                in_range;

    assign in_range = ({1'b0, cmd_channel_in} < CH_LIMIT);

    // Per-channel "can take a command" flags, padded to the full index range.
    always_comb begin
        free_pad                 = '0;
        free_pad[CHANNELS-1:0]   = ch_idle & ~abort_in;
    end

    // Commands to non-existent channels are always accepted and dropped.
    assign cmd_ready_out = in_range ? free_pad[cmd_channel_in] : 1'b1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign ch_start[i] = cmd_valid_in & cmd_ready_out &
                             (cmd_channel_in == CH_W'(i));

        step_channel #(
            .COUNT_W   (COUNT_W),
            .PERIOD_W  (PERIOD_W),
            .PULSE_W   (PULSE_W),
            .DIR_SETUP (DIR_SETUP)
        ) u_channel (
            .clk        (clk_in),
            .rst_n      (reset_n_in),
            .start      (ch_start[i]),
            .cmd_dir    (cmd_dir_in),
            .cmd_count  (cmd_count_in),
            .cmd_period (cmd_period_in),
            .abort      (abort_in[i]),
            .enable     (step_enable_in[i]),
            .idle       (ch_idle[i]),
            .step       (step_out[i]),
            .dir        (dir_out[i]),
            .busy       (busy_out[i]),
            .done       (done_out[i])
        );
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus a random phase, all
// checked against a timeline model of each axis.
module tb_step_sequencer;

    // Three axes so that index 3 exists in the field but not as a channel.
    localparam int CHANNELS  = 3;
    localparam int COUNT_W   = 24;
    localparam int PERIOD_W  = 16;
    localparam int PULSE_W   = 8;
    localparam int DIR_SETUP = 8;
    localparam int CH_W      = 2;

    logic                clk_in = 1'b0;
    logic                reset_n_in;
    logic                cmd_valid_in;
    logic                cmd_ready_out;
    logic [CH_W-1:0]     cmd_channel_in;
    logic                cmd_dir_in;
    logic [COUNT_W-1:0]  cmd_count_in;
    logic [PERIOD_W-1:0] cmd_period_in;
    logic [CHANNELS-1:0] abort_in;
    logic [CHANNELS-1:0] step_enable_in;
    logic [CHANNELS-1:0] step_out;
    logic [CHANNELS-1:0] dir_out;
    logic [CHANNELS-1:0] busy_out;
    logic [CHANNELS-1:0] done_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: time since accept (only enabled cycles count) per axis.
    bit m_act [CHANNELS];
    int m_t   [CHANNELS];
    int m_end [CHANNELS];
    int m_p   [CHANNELS];
    bit m_dir [CHANNELS];
    bit m_zp  [CHANNELS];
    bit m_zd  [CHANNELS];

    int acc_cyc;
    int done_cyc;
    int watch;
    bit prev_step;
    int rises[$];
    int falls[$];

    step_sequencer #(
        .CHANNELS  (CHANNELS),
        .COUNT_W   (COUNT_W),
        .PERIOD_W  (PERIOD_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_ready_out  (cmd_ready_out),
        .cmd_channel_in (cmd_channel_in),
        .cmd_dir_in     (cmd_dir_in),
        .cmd_count_in   (cmd_count_in),
        .cmd_period_in  (cmd_period_in),
        .abort_in       (abort_in),
        .step_enable_in (step_enable_in),
        .step_out       (step_out),
        .dir_out        (dir_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #20 clk_in = ~clk_in;

    function automatic bit m_busy(input int c);
        return m_act[c] && (m_t[c] < m_end[c]);
    endfunction

    function automatic bit m_step(input int c);
        if (!m_busy(c) || m_t[c] < DIR_SETUP) return 1'b0;
        return ((m_t[c] - DIR_SETUP) % m_p[c]) < PULSE_W;
    endfunction

    function automatic bit m_done(input int c);
        return m_zd[c] || (m_act[c] && m_t[c] == m_end[c]);
    endfunction

    function automatic int rise_at(input int i);
        return (i < rises.size()) ? rises[i] : -1000;
    endfunction

    function automatic int fall_at(input int i);
        return (i < falls.size()) ? falls[i] : -1000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_end[i] = 0; m_p[i] = 1;
            m_dir[i] = 1'b0; m_zp[i] = 1'b0; m_zd[i] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_rec(input int w);
        watch = w;
        rises.delete();
        falls.delete();
        done_cyc  = -1;
        prev_step = 1'b0;
    endtask

    // One clock: check ready, advance the model at the edge, check pins.
    task automatic tick();
        int c;
        bit rdy;
        bit acc;
        int pp;
        #1;
        c   = int'(cmd_channel_in);
        rdy = (c >= CHANNELS) ? 1'b1 : (!m_busy(c) && !abort_in[c]);
        chk("cmd_ready", cmd_ready_out, rdy);
        acc = cmd_valid_in && rdy && reset_n_in;
        @(posedge clk_in);
        cyc++;
        if (!reset_n_in) begin
            model_reset();
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (abort_in[i]) begin
                    m_act[i] = 1'b0; m_zp[i] = 1'b0; m_zd[i] = 1'b0;
                end else begin
                    m_zd[i] = m_zp[i];
                    m_zp[i] = 1'b0;
                    if (m_act[i]) begin
                        if (m_t[i] >= m_end[i]) m_act[i] = 1'b0;
                        else if (step_enable_in[i]) m_t[i]++;
                    end
                end
            end
            if (acc && c < CHANNELS) begin
                if (cmd_count_in == '0) begin
                    m_zp[c] = 1'b1;
                end else begin
                    pp = int'(cmd_period_in);
                    if (pp < PULSE_W + 1) pp = PULSE_W + 1;
                    m_act[c] = 1'b1;
                    m_t[c]   = 0;
                    m_p[c]   = pp;
                    m_end[c] = DIR_SETUP + int'(cmd_count_in) * pp;
                    m_dir[c] = cmd_dir_in;
                end
            end
            if (acc) acc_cyc = cyc;
        end
        @(negedge clk_in);
        for (int i = 0; i < CHANNELS; i++) begin
            chk($sformatf("step[%0d]", i), step_out[i], m_step(i));
            chk($sformatf("dir[%0d]", i),  dir_out[i],  m_dir[i]);
            chk($sformatf("busy[%0d]", i), busy_out[i], m_busy(i));
            chk($sformatf("done[%0d]", i), done_out[i], m_done(i));
        end
        if (step_out[watch] === 1'b1 && !prev_step) rises.push_back(cyc);
        if (step_out[watch] === 1'b0 && prev_step)  falls.push_back(cyc);
        prev_step = (step_out[watch] === 1'b1);
        if (done_out[watch] === 1'b1) done_cyc = cyc;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int ch, input bit d, input int cnt, input int per);
        cmd_valid_in   = 1'b1;
        cmd_channel_in = CH_W'(ch);
        cmd_dir_in     = d;
        cmd_count_in   = COUNT_W'(cnt);
        cmd_period_in  = PERIOD_W'(per);
        tick();
        cmd_valid_in   = 1'b0;
    endtask

    initial begin
        reset_n_in     = 1'b0;
        cmd_valid_in   = 1'b0;
        cmd_channel_in = '0;
        cmd_dir_in     = 1'b0;
        cmd_count_in   = '0;
        cmd_period_in  = '0;
        abort_in       = '0;
        step_enable_in = '1;
        model_reset();
        clear_rec(0);

        // Reset state
        #1;
        chk("reset_step", step_out, 0);
        chk("reset_dir",  dir_out,  0);
        chk("reset_busy", busy_out, 0);
        chk("reset_done", done_out, 0);
        run(2);
        reset_n_in = 1'b1;
        run(2);

        // Basic move: 3 steps, period 20
        clear_rec(0);
        send(0, 1'b1, 3, 20);
        run(75);
        chk("basic_nrises", rises.size(), 3);
        chk("basic_rise0",  rise_at(0) - acc_cyc, 8);
        chk("basic_fall0",  fall_at(0) - acc_cyc, 16);
        chk("basic_rise1",  rise_at(1) - acc_cyc, 28);
        chk("basic_rise2",  rise_at(2) - acc_cyc, 48);
        chk("basic_done",   done_cyc - acc_cyc, 68);

        // Period clamp: 4 -> 9
        clear_rec(1);
        send(1, 1'b0, 2, 4);
        run(30);
        chk("clamp_spacing", rise_at(1) - rise_at(0), 9);
        chk("clamp_width",   fall_at(0) - rise_at(0), 8);
        chk("clamp_done",    done_cyc - acc_cyc, 26);

        // Zero count
        clear_rec(0);
        send(0, 1'b0, 0, 7);
        run(3);
        chk("zero_done",   done_cyc - acc_cyc, 1);
        chk("zero_nrises", rises.size(), 0);

        // Handshake: busy channel holds, idle channel and index 3 accept
        send(0, 1'b0, 5, 20);
        cmd_valid_in   = 1'b1;
        cmd_channel_in = 2'd0;
        cmd_count_in   = 24'd1;
        cmd_period_in  = 16'd10;
        #1 chk("hs_busy_ready", cmd_ready_out, 0);
        run(2);
        cmd_channel_in = 2'd1;
        #1 chk("hs_idle_ready", cmd_ready_out, 1);
        tick();
        cmd_channel_in = 2'd3;
        #1 chk("hs_oor_ready", cmd_ready_out, 1);
        tick();
        cmd_valid_in = 1'b0;
        run(110);

        // Pause 5 cycles in the middle of the first HIGH
        clear_rec(0);
        send(0, 1'b1, 2, 20);
        run(10);
        step_enable_in[0] = 1'b0;
        run(5);
        step_enable_in[0] = 1'b1;
        run(60);
        chk("pause_width", fall_at(0) - rise_at(0), 13);
        chk("pause_rise1", rise_at(1) - acc_cyc, 33);
        chk("pause_done",  done_cyc - acc_cyc, 53);

        // Abort during the second LOW; abort masks ready
        clear_rec(1);
        send(1, 1'b1, 10, 20);
        run(40);
        abort_in[1]    = 1'b1;
        cmd_valid_in   = 1'b1;
        cmd_channel_in = 2'd1;
        cmd_count_in   = 24'd2;
        #1 chk("abort_ready", cmd_ready_out, 0);
        tick();
        abort_in[1]  = 1'b0;
        cmd_valid_in = 1'b0;
        chk("abort_busy", busy_out[1], 0);
        chk("abort_step", step_out[1], 0);
        chk("abort_dir",  dir_out[1], 1);
        run(5);
        chk("abort_nodone", done_cyc, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a pulse
        clear_rec(0);
        send(0, 1'b1, 3, 20);
        run(10);
        #3 reset_n_in = 1'b0;
        #1;
        chk("rst_async_step", step_out, 0);
        chk("rst_async_busy", busy_out, 0);
        chk("rst_async_dir",  dir_out, 0);
        model_reset();
        run(2);
        reset_n_in = 1'b1;
        clear_rec(0);
        send(0, 1'b0, 2, 12);
        run(40);
        chk("rst_after_spacing", rise_at(1) - rise_at(0), 12);
        chk("rst_after_done",    done_cyc - acc_cyc, 32);

        // Random traffic
        for (int k = 0; k < 2500; k++) begin
            cmd_valid_in   = 1'($urandom_range(0, 1));
            cmd_channel_in = CH_W'($urandom_range(0, 3));
            cmd_dir_in     = 1'($urandom_range(0, 1));
            cmd_count_in   = COUNT_W'($urandom_range(0, 4));
            cmd_period_in  = PERIOD_W'($urandom_range(0, 24));
            for (int i = 0; i < CHANNELS; i++) begin
                step_enable_in[i] = ($urandom_range(0, 7) != 0);
                abort_in[i]       = ($urandom_range(0, 63) == 0);
            end
            tick();
        end
        cmd_valid_in   = 1'b0;
        abort_in       = '0;
        step_enable_in = '1;
        run(120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
